// File: rtl/alu_share_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module      : alu_share_arbiter_pkg
// Description : ALU opcodes, arbiter port indices and response-slot states.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_share_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
    localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
    localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'h5;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'h6;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'h7;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'h8;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'h9;
    localparam logic [OP_W-1:0] ALU_PASSB = 4'hA;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
//------------------------------------------------------------------------------
// Module      : alu
// Description : Single-cycle combinational ALU with zero flag.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu
    import alu_share_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_SLL:   y = a << b[4:0];
            ALU_SRL:   y = a >> b[4:0];
            ALU_SRA:   y = $signed(a) >>> b[4:0];
            ALU_SLT:   y = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {31'b0, (a < b)};
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

`default_nettype wire

// File: rtl/alu_resp_slot.sv
//------------------------------------------------------------------------------
// Module      : alu_resp_slot
// Description : One-entry registered response buffer with valid/ready output.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_resp_slot
    import alu_share_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] y_in,
    input  logic              zero_in,
    input  logic              resp_ready,
    output logic              can_accept,
    output logic              resp_valid,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    slot_state_t       r_state;
    logic [DATA_W-1:0] r_y;
    logic              r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_y     <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                SLOT_EMPTY: if (load) r_state <= SLOT_FULL;
                // a load in the drain cycle keeps the slot full with new data
                SLOT_FULL:  if (resp_ready && !load) r_state <= SLOT_EMPTY;
                default:    r_state <= SLOT_EMPTY;
            endcase
            if (load) begin
                r_y    <= y_in;
                r_zero <= zero_in;
            end
        end
    end

    assign resp_valid = (r_state == SLOT_FULL);
    assign can_accept = (r_state == SLOT_EMPTY) || resp_ready;
    assign y          = r_y;
    assign zero       = r_zero;

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
//------------------------------------------------------------------------------
// Module      : alu_share_arbiter
// Description : Two-port arbiter sharing one ALU, with per-port result slots.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter logic RR_EN = 1'b1,
    parameter int   CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [DATA_W-1:0] p0_a,
    input  logic [DATA_W-1:0] p0_b,
    input  logic [OP_W-1:0]   p0_op,
    output logic              p0_resp_valid,
    input  logic              p0_resp_ready,
    output logic [DATA_W-1:0] p0_y,
    output logic              p0_zero,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [DATA_W-1:0] p1_a,
    input  logic [DATA_W-1:0] p1_b,
    input  logic [OP_W-1:0]   p1_op,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [DATA_W-1:0] p1_y,
    output logic              p1_zero,
    output logic [CNT_W-1:0]  op_count
);

    logic              r_last_grant;
    logic [CNT_W-1:0]  r_op_count;
    logic              w_acc0, w_acc1;
    logic              w_elig0, w_elig1;
    logic              w_grant0, w_grant1;
    logic [DATA_W-1:0] w_alu_a, w_alu_b, w_alu_y;
    logic [OP_W-1:0]   w_alu_op;
    logic              w_alu_zero;

    // Reset gates eligibility so nothing is accepted in a reset cycle.
    assign w_elig0 = !rst && p0_req_valid && w_acc0;
    assign w_elig1 = !rst && p1_req_valid && w_acc1;

    assign w_grant0 = w_elig0 && (!w_elig1 || (RR_EN == 1'b0) || (r_last_grant == ARB_P1));
    assign w_grant1 = w_elig1 && (!w_elig0 || ((RR_EN == 1'b1) && (r_last_grant == ARB_P0)));

    assign p0_req_ready = w_grant0;
    assign p1_req_ready = w_grant1;

    assign w_alu_a  = w_grant1 ? p1_a  : p0_a;
    assign w_alu_b  = w_grant1 ? p1_b  : p0_b;
    assign w_alu_op = w_grant1 ? p1_op : p0_op;

    alu u_alu (
        .a    (w_alu_a),
        .b    (w_alu_b),
        .op   (w_alu_op),
        .y    (w_alu_y),
        .zero (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ARB_P1;
            r_op_count   <= '0;
        end else begin
            if (w_grant0) begin
                r_last_grant <= ARB_P0;
            end else if (w_grant1) begin
                r_last_grant <= ARB_P1;
            end
            if ((w_grant0 || w_grant1) && (r_op_count != {CNT_W{1'b1}})) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign op_count = r_op_count;

    alu_resp_slot u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (w_grant0),
        .y_in       (w_alu_y),
        .zero_in    (w_alu_zero),
        .resp_ready (p0_resp_ready),
        .can_accept (w_acc0),
        .resp_valid (p0_resp_valid),
        .y          (p0_y),
        .zero       (p0_zero)
    );

    alu_resp_slot u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (w_grant1),
        .y_in       (w_alu_y),
        .zero_in    (w_alu_zero),
        .resp_ready (p1_resp_ready),
        .can_accept (w_acc1),
        .resp_valid (p1_resp_valid),
        .y          (p1_y),
        .zero       (p1_zero)
    );

endmodule

`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational `alu` between two requesters, e.g. port 0 = execute stage and port 1 = address-generation/branch unit. Both sides use a valid/ready handshake. The block arbitrates one ALU operation per cycle, round-robin by default. Each result is registered into a per-port one-entry response buffer with its own valid/ready handshake. A saturating counter records the number of issued operations.

Parameters:
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
CNT_W, 16, width of the op_count saturating counter.
Data width is fixed at 32 and op width at 4, matching `alu` and the ALU_* codes in decode.vh.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
p0_req_valid  in  1  port 0 has an operation to issue.
p0_req_ready  out  1  port 0 operation accepted this cycle.
p0_a  in  32  port 0 operand a.
p0_b  in  32  port 0 operand b.
p0_op  in  4  port 0 ALU_* opcode.
p0_resp_valid  out  1  port 0 result buffer full.
p0_resp_ready  in  1  port 0 consumer takes the result.
p0_y  out  32  port 0 registered result.
p0_zero  out  1  port 0 registered zero flag.
p1_* (same nine signals)  -  -  port 1, identical semantics.
op_count  out  CNT_W  total operations issued, saturating.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pN_resp_valid=0, pN_y=0, pN_zero=0, op_count=0, last_grant=1.
  - While rst=1, pN_req_ready=0.
  - Asserting reset mid-operation discards any buffered result. No response is produced for an operation accepted in the same cycle that reset is sampled.
- Eligibility: port N is eligible when pN_req_valid=1 and its buffer can accept, i.e. pN_resp_valid=0, or pN_resp_valid=1 with pN_resp_ready=1 in the same cycle (drain-and-refill).
- Grant (combinational, at most one per cycle):
  - One eligible port: that port is granted.
  - Both eligible, RR_EN=1: grant the port != last_grant.
  - Both eligible, RR_EN=0: grant port 0.
  - pN_req_ready = grant_N.
  - Requesters must not make valid depend on ready. Once asserted, pN_req_valid and the operands must stay stable until accepted.
- Issue: the ALU a/b/op mux selects the granted port's inputs. On the clk edge where grant_N=1:
  - pN_y <= alu.y, pN_zero <= alu.zero, pN_resp_valid <= 1.
  - last_grant <= N.
  - op_count increments, holding at all-ones (no wrap).
- Latency and throughput:
  - Result is visible exactly 1 cycle after acceptance.
  - Aggregate throughput is 1 op/cycle.
  - A single port sustains 1 op/cycle only while its consumer holds resp_ready=1.
- Response: pN_resp_valid clears on a cycle where pN_resp_ready=1 and no new grant is made to port N. If a grant to N occurs in the same cycle, the new result replaces the old one and resp_valid stays 1.
- Backpressure: while port N's buffer is full and not being drained, pN_req_ready=0. The other port proceeds unaffected, with no head-of-line blocking.
- No grant: the ALU mux defaults to port 0 inputs. No state changes except response drains.
- State: last_grant (1b), two buffers of 34b each, op_count. The per-port buffer is a 2-state machine: EMPTY -> FULL on grant; FULL -> EMPTY on drain without grant; FULL -> FULL on drain+grant.

Decomposition:
- ALU_* opcodes come from the existing decode.vh. Add ARB_P0/ARB_P1 index constants there.
- Instantiate the existing `alu` once.
- One natural sub-module: `alu_resp_slot`, the one-entry response buffer with full flag and valid/ready logic, instantiated twice.

Test Plan:
1. Port 0 only, AND, a=F0F0F0F0, b=0F0F0F0F -> p0_req_ready=1 in the same cycle; next cycle p0_resp_valid=1, p0_y=00000000, p0_zero=1; op_count=1.
2. Both ports valid every cycle, RR_EN=1, p0 OR (F0F0F0F0|0F0F0F0F), p1 XOR (AAAA5555^FFFF0000), both resp_ready=1 -> grants 0,1,0,1; p0_y=FFFFFFFF, p1_y=55555555, p0_zero=0.
3. Same as 2 with RR_EN=0 -> port 0 granted every cycle; port 1 never granted while p0_req_valid=1.
4. p1_resp_ready=0 after one p1 result -> p1_req_ready stays 0 and p1_y holds 55555555. Port 0 continues issuing each cycle. When p1_resp_ready rises with p1_req_valid=1, drain and refill happen in the same cycle and p1_resp_valid remains 1.
5. rst=1 while both buffers are full and both ports request -> next cycle resp_valid=0, y=0, op_count=0, req_ready=0. After release, port 0 wins the first contested grant.
6. CNT_W=4, 20 back-to-back accepted ops -> op_count reaches F after 15 ops and stays F.
